// File: rtl/tx_frame_reader_if.sv
// Byte stream from tx_frame_reader to the TX MAC:
// valid/ready handshake with a last-byte marker.
interface tx_frame_reader_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    output tx_last,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  tx_last,
    output tx_ready
  );
endinterface

// File: rtl/tx_frame_reader.sv
// Pulls completed frames out of the RX byte FIFO and streams
// them to the TX MAC, with a length queue and inter-frame gap.
module tx_frame_reader #(
  parameter int LEN_DEPTH  = 4,
  parameter int IFG_CYCLES = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        len_in,
  input  logic              len_we,
  input  logic              fifo_empty,
  input  logic [7:0]        fifo_data,
  output logic              fifo_rd,
  tx_frame_reader_if.master tx,
  output logic              len_ovf,
  output logic              busy,
  output logic [15:0]       frames_sent
);
  localparam int LW = $clog2(LEN_DEPTH);
  localparam logic [LW:0] LQ_FULL =
    (LW+1)'(LEN_DEPTH);
  localparam logic [15:0] GAP_LOAD =
    (IFG_CYCLES > 0) ? 16'(IFG_CYCLES - 1) : 16'd0;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    GAP
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    lq_mem [LEN_DEPTH];
  logic [LW-1:0] lq_wp_q, lq_wp_d;
  logic [LW-1:0] lq_rp_q, lq_rp_d;
  logic [LW:0]   lq_cnt_q, lq_cnt_d;
  logic [7:0]    rem_rd_q, rem_rd_d;
  logic [7:0]    rem_tx_q, rem_tx_d;
  logic [15:0]   gap_q, gap_d;
  logic [7:0]    ob_mem [3];
  logic [1:0]    ob_wp_q, ob_wp_d;
  logic [1:0]    ob_rp_q, ob_rp_d;
  logic [1:0]    ob_cnt_q, ob_cnt_d;
  logic          infl_q, infl_d;
  logic          len_ovf_q, len_ovf_d;
  logic [15:0]   frames_q, frames_d;

  logic       len_ok;
  logic       lq_push;
  logic       lq_pop;
  logic       hs;
  logic       last_hs;
  logic [2:0] outstanding;

  assign tx.tx_valid  = (ob_cnt_q != 2'd0);
  assign tx.tx_data   = ob_mem[ob_rp_q];
  assign tx.tx_last   = tx.tx_valid
                     && (rem_tx_q == 8'd1);
  assign len_ovf      = len_ovf_q;
  assign frames_sent  = frames_q;
  assign busy         = (state_q != IDLE)
                     || (ob_cnt_q != 2'd0);

  always_comb begin
    len_ok  = len_we && (len_in != 8'd0);
    lq_pop  = (state_q == IDLE)
           && (lq_cnt_q != '0);
    // a pop frees a slot, so a full queue still takes the push
    lq_push = len_ok
           && ((lq_cnt_q != LQ_FULL) || lq_pop);
    len_ovf_d = len_ok && !lq_push;

    lq_wp_d = lq_push ? lq_wp_q + LW'(1) : lq_wp_q;
    lq_rp_d = lq_pop  ? lq_rp_q + LW'(1) : lq_rp_q;
    lq_cnt_d = lq_cnt_q
             + (LW+1)'(lq_push)
             - (LW+1)'(lq_pop);

    hs      = tx.tx_valid && tx.tx_ready;
    last_hs = hs && tx.tx_last;

    outstanding = {1'b0, ob_cnt_q}
                + {2'b00, infl_q};
    fifo_rd = (state_q == READ)
           && (rem_rd_q != 8'd0)
           && !fifo_empty
           && (outstanding < 3'd3);
    infl_d  = fifo_rd;

    ob_wp_d = ob_wp_q;
    if (infl_q)
      ob_wp_d = (ob_wp_q == 2'd2) ? 2'd0
              : ob_wp_q + 2'd1;
    ob_rp_d = ob_rp_q;
    if (hs)
      ob_rp_d = (ob_rp_q == 2'd2) ? 2'd0
              : ob_rp_q + 2'd1;
    ob_cnt_d = ob_cnt_q
             + {1'b0, infl_q}
             - {1'b0, hs};

    state_d  = state_q;
    rem_rd_d = rem_rd_q;
    rem_tx_d = rem_tx_q;
    gap_d    = gap_q;
    frames_d = frames_q;
    if (last_hs)
      frames_d = frames_q + 16'd1;

    unique case (state_q)
      IDLE: begin
        if (lq_pop) begin
          rem_rd_d = lq_mem[lq_rp_q];
          rem_tx_d = lq_mem[lq_rp_q];
          state_d  = READ;
        end
      end
      READ: begin
        if (fifo_rd)
          rem_rd_d = rem_rd_q - 8'd1;
        if (hs)
          rem_tx_d = rem_tx_q - 8'd1;
        if (last_hs) begin
          gap_d   = GAP_LOAD;
          state_d = (IFG_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_q == 16'd0)
          state_d = IDLE;
        else
          gap_d = gap_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (lq_push && !rst)
      lq_mem[lq_wp_q] <= len_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lq_wp_q   <= '0;
      lq_rp_q   <= '0;
      lq_cnt_q  <= '0;
      rem_rd_q  <= '0;
      rem_tx_q  <= '0;
      gap_q     <= '0;
      ob_wp_q   <= '0;
      ob_rp_q   <= '0;
      ob_cnt_q  <= '0;
      infl_q    <= 1'b0;
      len_ovf_q <= 1'b0;
      frames_q  <= '0;
      for (int i = 0; i < 3; i++)
        ob_mem[i] <= '0;
    end else begin
      state_q   <= state_d;
      lq_wp_q   <= lq_wp_d;
      lq_rp_q   <= lq_rp_d;
      lq_cnt_q  <= lq_cnt_d;
      rem_rd_q  <= rem_rd_d;
      rem_tx_q  <= rem_tx_d;
      gap_q     <= gap_d;
      ob_wp_q   <= ob_wp_d;
      ob_rp_q   <= ob_rp_d;
      ob_cnt_q  <= ob_cnt_d;
      infl_q    <= infl_d;
      len_ovf_q <= len_ovf_d;
      frames_q  <= frames_d;
      if (infl_q)
        ob_mem[ob_wp_q] <= fifo_data;
    end
  end
endmodule
